msf_time_sync: RTL and testbench

- Controller for the clock's BCD digit chain.
- Generates the one-second increment pulse that drives the seconds-units digit.
- Captures decoded MSF frames, checks that they are plausible, and loads all six digits at the next minute marker.
- Tracks sync status: unsynced, locked, or in holdover.
- Sits between the MSF bit decoder and the HH:MM:SS digit cascade.

---
 rtl/msf_time_sync.sv | 150 +++++++++++++++
 tb/tb_msf_time_sync.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/msf_time_sync.sv
// rtl/msf_time_sync.sv - MSF sync controller: 1 Hz increment, frame capture/load, lock tracking.
// Define MSF_SYNC_FRAME_CHECK_EN to discard implausible frames before they become pending.
module msf_time_sync #(
    parameter int CLK_DIV      = 32768,
    parameter int HOLDOVER_MIN = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       minute_mark_i,
    input  logic       frame_valid_i,
    input  logic [5:0] frame_hours_i,
    input  logic [6:0] frame_minutes_i,
    output logic       inc_o,
    output logic       load_o,
    output logic [3:0] ld_sec_u_o,
    output logic [2:0] ld_sec_t_o,
    output logic [3:0] ld_min_u_o,
    output logic [2:0] ld_min_t_o,
    output logic [3:0] ld_hr_u_o,
    output logic [1:0] ld_hr_t_o,
    output logic       synced_o,
    output logic [1:0] state_o
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MW = $clog2(HOLDOVER_MIN + 1);

    typedef enum logic [1:0] {
        ST_UNSYNCED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_HOLDOVER = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0]      sec_q, sec_d;
    logic [MW-1:0]   msl_q, msl_d;
    logic            pend_q, pend_d;
    logic [5:0]      pend_hr_q, pend_hr_d;
    logic [6:0]      pend_min_q, pend_min_d;
    logic            inc_q, inc_d;
    logic            load_q, load_d;
    logic            synced_q, synced_d;
    logic [5:0]      ld_hr_q, ld_hr_d;
    logic [6:0]      ld_min_q, ld_min_d;
    logic            frame_ok;

`ifdef MSF_SYNC_FRAME_CHECK_EN
    // Hours tens of 2 only allows units 0..3.
    always_comb begin
        frame_ok = (frame_minutes_i[3:0] <= 4'd9) && (frame_minutes_i[6:4] <= 3'd5) &&
                   (frame_hours_i[3:0] <= 4'd9) && (frame_hours_i[5:4] <= 2'd2) &&
                   !((frame_hours_i[5:4] == 2'd2) && (frame_hours_i[3:0] > 4'd3));
    end
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_d      = sec_q;
        msl_d      = msl_q;
        pend_d     = pend_q;
        pend_hr_d  = pend_hr_q;
        pend_min_d = pend_min_q;
        inc_d      = 1'b0;
        load_d     = 1'b0;
        ld_hr_d    = ld_hr_q;
        ld_min_d   = ld_min_q;

        if (minute_mark_i && pend_q) begin
            // Load realigns everything and takes priority over a coincident wrap.
            load_d   = 1'b1;
            ld_hr_d  = pend_hr_q;
            ld_min_d = pend_min_q;
            presc_d  = '0;
            sec_d    = '0;
            msl_d    = '0;
            pend_d   = 1'b0;
            state_d  = ST_LOCKED;
        end else begin
            if (presc_q == PW'(CLK_DIV - 1)) begin
                presc_d = '0;
                inc_d   = 1'b1;
                if (sec_q == 6'd59) begin
                    sec_d = '0;
                    if (msl_q < MW'(HOLDOVER_MIN))
                        msl_d = msl_q + MW'(1);
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
            if ((state_q == ST_LOCKED) && (msl_d == MW'(HOLDOVER_MIN)))
                state_d = ST_HOLDOVER;
        end

        // Evaluated after the marker so a same-cycle frame stays pending for the next one.
        if (frame_valid_i && frame_ok) begin
            pend_d     = 1'b1;
            pend_hr_d  = frame_hours_i;
            pend_min_d = frame_minutes_i;
        end

        synced_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_UNSYNCED;
            presc_q    <= '0;
            sec_q      <= '0;
            msl_q      <= '0;
            pend_q     <= 1'b0;
            pend_hr_q  <= '0;
            pend_min_q <= '0;
            inc_q      <= 1'b0;
            load_q     <= 1'b0;
            synced_q   <= 1'b0;
            ld_hr_q    <= '0;
            ld_min_q   <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            msl_q      <= msl_d;
            pend_q     <= pend_d;
            pend_hr_q  <= pend_hr_d;
            pend_min_q <= pend_min_d;
            inc_q      <= inc_d;
            load_q     <= load_d;
            synced_q   <= synced_d;
            ld_hr_q    <= ld_hr_d;
            ld_min_q   <= ld_min_d;
        end
    end

    assign inc_o      = inc_q;
    assign load_o     = load_q;
    assign ld_sec_u_o = 4'd0;
    assign ld_sec_t_o = 3'd0;
    assign ld_min_u_o = ld_min_q[3:0];
    assign ld_min_t_o = ld_min_q[6:4];
    assign ld_hr_u_o  = ld_hr_q[3:0];
    assign ld_hr_t_o  = ld_hr_q[5:4];
    assign synced_o   = synced_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_msf_time_sync.sv
// tb/tb_msf_time_sync.sv - directed plus random bench for msf_time_sync against a cycle-count model.
module tb_msf_time_sync;
    localparam int CLK_DIV = 10;
    localparam int HM      = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       minute_mark_i = 1'b0;
    logic       frame_valid_i = 1'b0;
    logic [5:0] frame_hours_i = 6'd0;
    logic [6:0] frame_minutes_i = 7'd0;
    logic       inc_o, load_o, synced_o;
    logic [3:0] ld_sec_u_o, ld_min_u_o, ld_hr_u_o;
    logic [2:0] ld_sec_t_o, ld_min_t_o;
    logic [1:0] ld_hr_t_o, state_o;

    msf_time_sync #(.CLK_DIV(CLK_DIV), .HOLDOVER_MIN(HM)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .minute_mark_i(minute_mark_i), .frame_valid_i(frame_valid_i),
        .frame_hours_i(frame_hours_i), .frame_minutes_i(frame_minutes_i),
        .inc_o(inc_o), .load_o(load_o),
        .ld_sec_u_o(ld_sec_u_o), .ld_sec_t_o(ld_sec_t_o),
        .ld_min_u_o(ld_min_u_o), .ld_min_t_o(ld_min_t_o),
        .ld_hr_u_o(ld_hr_u_o), .ld_hr_t_o(ld_hr_t_o),
        .synced_o(synced_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;
    int inc_seen = 0;

    // Reference: time is measured in edges since the last realignment (reset or load).
    int         cyc, t0;
    logic       m_pend;
    logic [5:0] m_phr;
    logic [6:0] m_pmin;
    logic [1:0] m_state;
    logic       m_load, m_inc;
    logic [5:0] m_hr;
    logic [6:0] m_min;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit plausible(input logic [5:0] h, input logic [6:0] m);
`ifdef MSF_SYNC_FRAME_CHECK_EN
        int hu, ht, mu, mt;
        hu = int'(h[3:0]); ht = int'(h[5:4]);
        mu = int'(m[3:0]); mt = int'(m[6:4]);
        return (mu <= 9) && (mt <= 5) && (hu <= 9) && (ht <= 2) && (ht * 10 + hu <= 23);
`else
        return (h == h) && (m == m);
`endif
    endfunction

    task automatic model_reset();
        cyc = 0; t0 = 0; m_pend = 1'b0; m_phr = '0; m_pmin = '0;
        m_state = 2'b00; m_load = 1'b0; m_inc = 1'b0; m_hr = '0; m_min = '0;
    endtask

    task automatic model_edge(input logic mm, input logic fv, input logic [5:0] h, input logic [6:0] m);
        cyc++;
        m_load = 1'b0;
        m_inc  = 1'b0;
        if (mm && m_pend) begin
            m_load = 1'b1; m_hr = m_phr; m_min = m_pmin;
            m_pend = 1'b0; t0 = cyc; m_state = 2'b01;
        end else begin
            m_inc = ((cyc - t0) % CLK_DIV) == 0;
            if (m_state == 2'b01 && (cyc - t0) / CLK_DIV >= 60 * HM)
                m_state = 2'b10;
        end
        if (fv && plausible(h, m)) begin
            m_pend = 1'b1; m_phr = h; m_pmin = m;
        end
    endtask

    task automatic check_outputs();
        chk("inc", 32'(inc_o), 32'(m_inc));
        chk("load", 32'(load_o), 32'(m_load));
        chk("state", 32'(state_o), 32'(m_state));
        chk("synced", 32'(synced_o), 32'(m_state == 2'b01));
        chk("ld_hr_u", 32'(ld_hr_u_o), 32'(m_hr[3:0]));
        chk("ld_hr_t", 32'(ld_hr_t_o), 32'(m_hr[5:4]));
        chk("ld_min_u", 32'(ld_min_u_o), 32'(m_min[3:0]));
        chk("ld_min_t", 32'(ld_min_t_o), 32'(m_min[6:4]));
        chk("ld_sec", 32'({ld_sec_t_o, ld_sec_u_o}), 32'd0);
        chk("inc_load_excl", 32'(inc_o & load_o), 32'd0);
    endtask

    task automatic step(input logic mm, input logic fv, input logic [5:0] h, input logic [6:0] m);
        minute_mark_i = mm; frame_valid_i = fv; frame_hours_i = h; frame_minutes_i = m;
        @(posedge clk);
        model_edge(mm, fv, h, m);
        #1;
        minute_mark_i = 1'b0; frame_valid_i = 1'b0;
        if (inc_o) inc_seen++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 7'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [5:0] rh;
        logic [6:0] rm;

        // Reset and free-run
        do_reset();
        inc_seen = 0;
        idle(35);
        chk("free_run_incs", 32'(inc_seen), 32'd3);

        // Frame 13:47 then marker three cycles later
        step(1'b0, 1'b1, 6'h13, 7'h47);
        idle(3);
        step(1'b1, 1'b0, 6'd0, 7'd0);
        chk("f1_load", 32'(load_o), 32'd1);
        chk("f1_hr", 32'({ld_hr_t_o, ld_hr_u_o}), 32'h13);
        chk("f1_min", 32'({ld_min_t_o, ld_min_u_o}), 32'h47);
        chk("f1_state", 32'(state_o), 32'd1);
        idle(9);
        step(1'b0, 1'b0, 6'd0, 7'd0);
        chk("f1_first_inc", 32'(inc_o), 32'd1);

        // Implausible hours 25
        step(1'b0, 1'b1, 6'h25, 7'h10);
        idle(2);
        step(1'b1, 1'b0, 6'd0, 7'd0);
`ifdef MSF_SYNC_FRAME_CHECK_EN
        chk("bad_noload", 32'(load_o), 32'd0);
        chk("bad_state", 32'(state_o), 32'd1);
`else
        chk("bad_load", 32'(load_o), 32'd1);
        chk("bad_hr", 32'({ld_hr_t_o, ld_hr_u_o}), 32'h25);
`endif

        // Marker coincident with prescaler wrap
        step(1'b0, 1'b1, 6'h08, 7'h30);
        while (((cyc + 1 - t0) % CLK_DIV) != 0) step(1'b0, 1'b0, 6'd0, 7'd0);
        step(1'b1, 1'b0, 6'd0, 7'd0);
        chk("wrap_load", 32'(load_o), 32'd1);
        chk("wrap_inc", 32'(inc_o), 32'd0);

        // Holdover after HM minutes without a load
        idle(1205);
        chk("ho_state", 32'(state_o), 32'd2);
        chk("ho_synced", 32'(synced_o), 32'd0);
        step(1'b0, 1'b1, 6'h21, 7'h05);
        step(1'b1, 1'b0, 6'd0, 7'd0);
        chk("ho_relock", 32'(state_o), 32'd1);

        // Reset between frame and marker drops the pending frame
        step(1'b0, 1'b1, 6'h09, 7'h59);
        idle(2);
        do_reset();
        idle(3);
        step(1'b1, 1'b0, 6'd0, 7'd0);
        chk("rst_noload", 32'(load_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);

        // Random frames and markers, including coincident ones
        for (int i = 0; i < 600; i++) begin
            rh = 6'($urandom_range(0, 63));
            rm = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) begin
                rh = 6'({2'($urandom_range(0, 2)), 4'($urandom_range(0, 3))});
                rm = 7'({3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
            end
            step(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 9) == 0), rh, rm);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
